// File: rtl/sd_init_seq_if.sv
// sd_init_seq_if
// Command-controller bus between the SD init/read sequencer (master) and the
// SD command-line controller (slave).
//   cc_start    master->slave  one-cycle command start pulse
//   cc_precnt   master->slave  idle sdclk cycles before the command
//   cc_cmd      master->slave  command index
//   cc_arg      master->slave  command argument
//   cc_clkdiv   master->slave  sdclk divider
//   cc_busy     slave->master  controller busy
//   cc_done     slave->master  command finished pulse
//   cc_timeout  slave->master  with cc_done: no response
//   cc_syntaxe  slave->master  with cc_done: malformed response
//   cc_resparg  slave->master  response argument, valid with cc_done
interface sd_init_seq_if;
    logic        cc_start;
    logic [15:0] cc_precnt;
    logic [5:0]  cc_cmd;
    logic [31:0] cc_arg;
    logic [15:0] cc_clkdiv;
    logic        cc_busy;
    logic        cc_done;
    logic        cc_timeout;
    logic        cc_syntaxe;
    logic [31:0] cc_resparg;

    modport master (
        output cc_start, cc_precnt, cc_cmd, cc_arg, cc_clkdiv,
        input  cc_busy, cc_done, cc_timeout, cc_syntaxe, cc_resparg
    );

    modport slave (
        input  cc_start, cc_precnt, cc_cmd, cc_arg, cc_clkdiv,
        output cc_busy, cc_done, cc_timeout, cc_syntaxe, cc_resparg
    );
endinterface

// File: rtl/sd_init_seq.sv
// sd_init_seq
// SD card power-up / identification sequencer followed by CMD17 single-block
// read command issue. Drives the command-line controller through cc.
//   clk, rst      system clock, async active-high reset
//   reinit        restart identification (honoured in READY / ERROR only)
//   cc            command-controller bus (master side)
//   rd_req        read request, sampled while rd_rdy=1, with rd_sector
//   rd_rdy        ready for a read request
//   rd_done       pulse: CMD17 response OK
//   rd_err        pulse: CMD17 failed on every attempt
//   card_ready    identification complete, fast clock active
//   init_err      sticky identification failure
//   card_type     0 none, 1 SDv1, 2 SDv2 SC, 3 SDv2 HC
//   rca           relative card address
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ISSUE    | wait for controller idle, launch command of current step
// WAIT     | command in flight, act on cc_done only
// FAST     | switch to fast sdclk once controller is idle
// READY    | identified, accepting read requests
// ERROR    | identification failed, wait for reinit
module sd_init_seq #(
    parameter logic [15:0] SLOWDIV      = 16'd99,
    parameter logic [15:0] FASTDIV      = 16'd1,
    parameter logic [15:0] PRE_CLKS     = 16'd80,
    parameter logic [15:0] GAP_CLKS     = 16'd8,
    parameter logic [15:0] ACMD41_TRIES = 16'd2000,
    parameter logic [3:0]  CMD_TRIES    = 4'd4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              reinit,
    sd_init_seq_if.master     cc,
    input  logic              rd_req,
    input  logic [31:0]       rd_sector,
    output logic              rd_rdy,
    output logic              rd_done,
    output logic              rd_err,
    output logic              card_ready,
    output logic              init_err,
    output logic [1:0]        card_type,
    output logic [15:0]       rca
);
    typedef enum logic [2:0] {ST_ISSUE, ST_WAIT, ST_FAST, ST_READY, ST_ERROR} state_t;
    typedef enum logic [3:0] {
        C_CMD0, C_CMD8, C_CMD55, C_ACMD41, C_CMD2, C_CMD3, C_CMD7, C_CMD16, C_CMD17
    } step_t;

    state_t      state_q, state_d;
    step_t       step_q, step_d;
    logic        start_q, start_d;
    logic [5:0]  cmd_q, cmd_d;
    logic [31:0] arg_q, arg_d;
    logic [15:0] pre_q, pre_d;
    logic [15:0] clkdiv_q, clkdiv_d;
    logic        rd_done_q, rd_done_d;
    logic        rd_err_q, rd_err_d;
    logic        ready_q, ready_d;
    logic        ierr_q, ierr_d;
    logic [1:0]  type_q, type_d;
    logic [15:0] rca_q, rca_d;
    // CMD8 either times out (v1) or echoes the check pattern (v2); any other
    // outcome ends in ERROR, so a single flag captures the version.
    logic        v2_q, v2_d;
    logic [31:0] sector_q, sector_d;
    logic [3:0]  tries_q, tries_d;
    logic [15:0] poll_q, poll_d;

    logic [5:0]  step_cmd;
    logic [31:0] step_arg;
    logic        fail, do_retry, go_err, do_reinit;
    logic [3:0]  tries_inc;
    logic [15:0] poll_inc;
    logic        unused_resp;

    assign unused_resp = ^cc.cc_resparg[15:12];

    always_comb begin
        step_cmd = 6'd0;
        step_arg = 32'h0;
        case (step_q)
            C_CMD0:   step_cmd = 6'd0;
            C_CMD8:   begin step_cmd = 6'd8;  step_arg = 32'h0000_01AA; end
            C_CMD55:  step_cmd = 6'd55;
            C_ACMD41: begin
                step_cmd = 6'd41;
                step_arg = v2_q ? 32'h4010_0000 : 32'h0010_0000;
            end
            C_CMD2:   step_cmd = 6'd2;
            C_CMD3:   step_cmd = 6'd3;
            C_CMD7:   begin step_cmd = 6'd7;  step_arg = {rca_q, 16'h0}; end
            C_CMD16:  begin step_cmd = 6'd16; step_arg = 32'd512; end
            C_CMD17:  begin
                step_cmd = 6'd17;
                step_arg = (type_q == 2'd3) ? sector_q : {sector_q[22:0], 9'b0};
            end
            default:  step_cmd = 6'd0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        step_d    = step_q;
        start_d   = 1'b0;
        cmd_d     = cmd_q;
        arg_d     = arg_q;
        pre_d     = pre_q;
        clkdiv_d  = clkdiv_q;
        rd_done_d = 1'b0;
        rd_err_d  = 1'b0;
        ready_d   = ready_q;
        ierr_d    = ierr_q;
        type_d    = type_q;
        rca_d     = rca_q;
        v2_d      = v2_q;
        sector_d  = sector_q;
        tries_d   = tries_q;
        poll_d    = poll_q;
        fail      = cc.cc_timeout | cc.cc_syntaxe;
        tries_inc = tries_q + 4'd1;
        poll_inc  = poll_q + 16'd1;
        do_retry  = 1'b0;
        go_err    = 1'b0;
        do_reinit = 1'b0;

        case (state_q)
            ST_ISSUE: begin
                if (!cc.cc_busy) begin
                    cmd_d   = step_cmd;
                    arg_d   = step_arg;
                    pre_d   = (step_q == C_CMD0) ? PRE_CLKS : GAP_CLKS;
                    start_d = 1'b1;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cc.cc_done) begin
                    state_d = ST_ISSUE;
                    tries_d = 4'd0;
                    case (step_q)
                        C_CMD0: begin
                            poll_d = 16'd0;
                            step_d = C_CMD8;
                        end
                        C_CMD8: begin
                            if (cc.cc_timeout) begin
                                v2_d   = 1'b0;
                                step_d = C_CMD55;
                            end else if (!cc.cc_syntaxe && cc.cc_resparg[11:0] == 12'h1AA) begin
                                v2_d   = 1'b1;
                                step_d = C_CMD55;
                            end else begin
                                go_err = 1'b1;
                            end
                        end
                        C_CMD55: if (fail) do_retry = 1'b1; else step_d = C_ACMD41;
                        C_ACMD41: begin
                            // R3 has no CRC/index, so only a timeout counts as failure.
                            if (cc.cc_timeout) begin
                                do_retry = 1'b1;
                            end else if (!cc.cc_resparg[31]) begin
                                if (poll_inc >= ACMD41_TRIES) begin
                                    go_err = 1'b1;
                                end else begin
                                    poll_d = poll_inc;
                                    step_d = C_CMD55;
                                end
                            end else begin
                                poll_d = 16'd0;
                                if (!v2_q)
                                    type_d = 2'd1;
                                else
                                    type_d = cc.cc_resparg[30] ? 2'd3 : 2'd2;
                                step_d = C_CMD2;
                            end
                        end
                        C_CMD2: if (fail) do_retry = 1'b1; else step_d = C_CMD3;
                        C_CMD3: begin
                            if (fail) begin
                                do_retry = 1'b1;
                            end else begin
                                rca_d  = cc.cc_resparg[31:16];
                                step_d = C_CMD7;
                            end
                        end
                        C_CMD7: begin
                            if (fail)
                                do_retry = 1'b1;
                            else if (type_q == 2'd3)
                                state_d = ST_FAST;
                            else
                                step_d = C_CMD16;
                        end
                        C_CMD16: if (fail) do_retry = 1'b1; else state_d = ST_FAST;
                        C_CMD17: begin
                            if (fail) begin
                                do_retry = 1'b1;
                            end else begin
                                rd_done_d = 1'b1;
                                state_d   = ST_READY;
                            end
                        end
                        default: go_err = 1'b1;
                    endcase

                    if (do_retry) begin
                        if (tries_inc < CMD_TRIES) begin
                            tries_d = tries_inc;
                            state_d = ST_ISSUE;
                        end else if (step_q == C_CMD17) begin
                            rd_err_d = 1'b1;
                            state_d  = ST_READY;
                        end else begin
                            go_err = 1'b1;
                        end
                    end
                    if (go_err) begin
                        state_d = ST_ERROR;
                        ierr_d  = 1'b1;
                        ready_d = 1'b0;
                    end
                end
            end
            ST_FAST: begin
                if (!cc.cc_busy) begin
                    clkdiv_d = FASTDIV;
                    ready_d  = 1'b1;
                    state_d  = ST_READY;
                end
            end
            ST_READY: begin
                if (reinit) begin
                    do_reinit = 1'b1;
                end else if (rd_req) begin
                    sector_d = rd_sector;
                    step_d   = C_CMD17;
                    tries_d  = 4'd0;
                    state_d  = ST_ISSUE;
                end
            end
            ST_ERROR: if (reinit) do_reinit = 1'b1;
            default:  state_d = ST_ERROR;
        endcase

        if (do_reinit) begin
            ready_d  = 1'b0;
            ierr_d   = 1'b0;
            type_d   = 2'd0;
            rca_d    = 16'd0;
            v2_d     = 1'b0;
            clkdiv_d = SLOWDIV;
            tries_d  = 4'd0;
            poll_d   = 16'd0;
            step_d   = C_CMD0;
            state_d  = ST_ISSUE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_ISSUE;
            step_q    <= C_CMD0;
            start_q   <= 1'b0;
            cmd_q     <= 6'd0;
            arg_q     <= 32'h0;
            pre_q     <= 16'd0;
            clkdiv_q  <= SLOWDIV;
            rd_done_q <= 1'b0;
            rd_err_q  <= 1'b0;
            ready_q   <= 1'b0;
            ierr_q    <= 1'b0;
            type_q    <= 2'd0;
            rca_q     <= 16'd0;
            v2_q      <= 1'b0;
            sector_q  <= 32'h0;
            tries_q   <= 4'd0;
            poll_q    <= 16'd0;
        end else begin
            state_q   <= state_d;
            step_q    <= step_d;
            start_q   <= start_d;
            cmd_q     <= cmd_d;
            arg_q     <= arg_d;
            pre_q     <= pre_d;
            clkdiv_q  <= clkdiv_d;
            rd_done_q <= rd_done_d;
            rd_err_q  <= rd_err_d;
            ready_q   <= ready_d;
            ierr_q    <= ierr_d;
            type_q    <= type_d;
            rca_q     <= rca_d;
            v2_q      <= v2_d;
            sector_q  <= sector_d;
            tries_q   <= tries_d;
            poll_q    <= poll_d;
        end
    end

    assign cc.cc_start  = start_q;
    assign cc.cc_cmd    = cmd_q;
    assign cc.cc_arg    = arg_q;
    assign cc.cc_precnt = pre_q;
    assign cc.cc_clkdiv = clkdiv_q;
    assign rd_rdy       = (state_q == ST_READY);
    assign rd_done      = rd_done_q;
    assign rd_err       = rd_err_q;
    assign card_ready   = ready_q;
    assign init_err     = ierr_q;
    assign card_type    = type_q;
    assign rca          = rca_q;
endmodule

// File: tb/tb_sd_init_seq.sv
module tb_sd_init_seq;
    logic        clk = 1'b0;
    logic        rst;
    logic        reinit;
    logic        rd_req;
    logic [31:0] rd_sector;
    logic        rd_rdy, rd_done, rd_err, card_ready, init_err;
    logic [1:0]  card_type;
    logic [15:0] rca;

    sd_init_seq_if cc_if();

    sd_init_seq dut (
        .clk        (clk),
        .rst        (rst),
        .reinit     (reinit),
        .cc         (cc_if),
        .rd_req     (rd_req),
        .rd_sector  (rd_sector),
        .rd_rdy     (rd_rdy),
        .rd_done    (rd_done),
        .rd_err     (rd_err),
        .card_ready (card_ready),
        .init_err   (init_err),
        .card_type  (card_type),
        .rca        (rca)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [5:0]  cmd;
        logic [31:0] arg;
        logic [15:0] pre;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;

    // card model knobs
    bit          m_v2, m_hc, m_always_busy, m_syn41, m_rd_fail;
    int          m_busy_left, m_cmd2_to;
    logic [15:0] m_rca;

    // controller model state
    bit          pend;
    int          cnt;
    logic [5:0]  infl_cmd;
    logic [31:0] infl_arg;

    // observation
    int          n_start[64];
    logic [31:0] last_arg[64];
    logic [15:0] last_pre[64];
    int          n_rd_done, n_rd_err;
    logic [15:0] prev_clkdiv;
    bit          prev_rst;

    task automatic chk(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic push(logic [5:0] c, logic [31:0] a, logic [15:0] p);
        exp_t e;
        e.cmd = c; e.arg = a; e.pre = p;
        exp_q.push_back(e);
    endtask

    // Expected command stream of one identification run, from the card's answers.
    task automatic expect_init(bit v2, bit hc, int busy_n, int cmd2_to,
                               logic [15:0] r, bit always_busy);
        int pairs;
        int n2;
        push(6'd0, 32'h0, 16'd80);
        push(6'd8, 32'h1AA, 16'd8);
        pairs = always_busy ? 2000 : busy_n + 1;
        for (int i = 0; i < pairs; i++) begin
            push(6'd55, 32'h0, 16'd8);
            push(6'd41, v2 ? 32'h4010_0000 : 32'h0010_0000, 16'd8);
        end
        if (!always_busy) begin
            n2 = (cmd2_to < 4) ? cmd2_to + 1 : 4;
            for (int i = 0; i < n2; i++) push(6'd2, 32'h0, 16'd8);
            if (cmd2_to < 4) begin
                push(6'd3, 32'h0, 16'd8);
                push(6'd7, {r, 16'h0}, 16'd8);
                if (!(v2 && hc)) push(6'd16, 32'd512, 16'd8);
            end
        end
    endtask

    task automatic clear_stats();
        for (int i = 0; i < 64; i++) begin
            n_start[i]  = 0;
            last_arg[i] = 32'h0;
            last_pre[i] = 16'h0;
        end
    endtask

    task automatic respond(logic [5:0] c);
        case (c)
            6'd0:  cc_if.cc_timeout = 1'b1;
            6'd8:  if (m_v2) cc_if.cc_resparg = 32'h1AA; else cc_if.cc_timeout = 1'b1;
            6'd41: begin
                if (m_syn41) cc_if.cc_syntaxe = 1'b1;
                if (m_always_busy || m_busy_left > 0) begin
                    cc_if.cc_resparg = 32'h00FF_8000;
                    if (m_busy_left > 0) m_busy_left--;
                end else begin
                    cc_if.cc_resparg = (m_v2 && m_hc) ? 32'hC0FF_8000 : 32'h80FF_8000;
                end
            end
            6'd2: begin
                if (m_cmd2_to > 0) begin
                    cc_if.cc_timeout = 1'b1;
                    m_cmd2_to--;
                end else begin
                    cc_if.cc_resparg = 32'h1234_ABCD;
                end
            end
            6'd3:  cc_if.cc_resparg = {m_rca, 16'h0};
            6'd17: if (m_rd_fail) cc_if.cc_timeout = 1'b1; else cc_if.cc_resparg = 32'h900;
            default: cc_if.cc_resparg = 32'h900;
        endcase
    endtask

    // One cycle: compare DUT outputs at the falling edge, then advance the controller/card model.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        if (!rst) begin
            if (cc_if.cc_start) begin
                n_start[cc_if.cc_cmd]++;
                last_arg[cc_if.cc_cmd] = cc_if.cc_arg;
                last_pre[cc_if.cc_cmd] = cc_if.cc_precnt;
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_cmd actual=%0d required=none", cc_if.cc_cmd);
                end else begin
                    e = exp_q.pop_front();
                    chk("cmd_index", 32'(cc_if.cc_cmd), 32'(e.cmd));
                    chk("cmd_arg", cc_if.cc_arg, e.arg);
                    chk("cmd_precnt", 32'(cc_if.cc_precnt), 32'(e.pre));
                end
            end
            if (pend) begin
                chk("hold_cmd", 32'(cc_if.cc_cmd), 32'(infl_cmd));
                chk("hold_arg", cc_if.cc_arg, infl_arg);
            end
            if (!prev_rst && cc_if.cc_clkdiv != prev_clkdiv)
                chk("clkdiv_change_while_busy", 32'(cc_if.cc_busy), 32'd0);
            if (rd_rdy) chk("rd_rdy_needs_card_ready", 32'(card_ready), 32'd1);
            if (rd_done) n_rd_done++;
            if (rd_err) n_rd_err++;
        end
        prev_clkdiv = cc_if.cc_clkdiv;
        prev_rst    = rst;

        cc_if.cc_done    = 1'b0;
        cc_if.cc_timeout = 1'b0;
        cc_if.cc_syntaxe = 1'b0;
        cc_if.cc_resparg = 32'h0;
        if (rst) begin
            pend = 1'b0;
            cc_if.cc_busy = 1'b0;
        end else begin
            if (pend) begin
                if (cnt == 0) begin
                    cc_if.cc_done = 1'b1;
                    respond(infl_cmd);
                    cc_if.cc_busy = 1'b0;
                    pend = 1'b0;
                end else begin
                    // qualifiers without cc_done must be ignored
                    if (cnt == 1) begin
                        cc_if.cc_timeout = 1'b1;
                        cc_if.cc_syntaxe = 1'b1;
                    end
                    cnt--;
                end
            end
            if (cc_if.cc_start && !pend) begin
                pend = 1'b1;
                cnt = 2;
                cc_if.cc_busy = 1'b1;
                infl_cmd = cc_if.cc_cmd;
                infl_arg = cc_if.cc_arg;
            end
        end
    endtask

    task automatic wait_settle(string name, int budget);
        int n = 0;
        while (!(card_ready || init_err) && n < budget) begin
            tick();
            n++;
        end
        if (!(card_ready || init_err)) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout actual=no_settle required=settle_in_%0d", name, budget);
        end
    endtask

    task automatic do_read(string name, logic [31:0] sector, bit hc, bit fail_all);
        int d0, e0, n;
        logic [31:0] a;
        a = hc ? sector : (sector << 9);
        for (int i = 0; i < (fail_all ? 4 : 1); i++) push(6'd17, a, 16'd8);
        m_rd_fail = fail_all;
        d0 = n_rd_done;
        e0 = n_rd_err;
        rd_sector = sector;
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        rd_sector = 32'hDEAD_BEEF;
        chk({name, "_rd_rdy_drop"}, 32'(rd_rdy), 32'd0);
        n = 0;
        while (n_rd_done == d0 && n_rd_err == e0 && n < 200) begin
            tick();
            n++;
        end
        chk({name, "_rd_done_cnt"}, 32'(n_rd_done - d0), fail_all ? 32'd0 : 32'd1);
        chk({name, "_rd_err_cnt"}, 32'(n_rd_err - e0), fail_all ? 32'd1 : 32'd0);
        chk({name, "_rd_rdy_back"}, 32'(rd_rdy), 32'd1);
        chk({name, "_card_ready"}, 32'(card_ready), 32'd1);
        chk({name, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
        m_rd_fail = 1'b0;
    endtask

    task automatic pulse_reinit();
        reinit = 1'b1;
        tick();
        reinit = 1'b0;
    endtask

    task automatic check_reset_values(string name);
        chk({name, "_cc_start"}, 32'(cc_if.cc_start), 32'd0);
        chk({name, "_cc_cmd"}, 32'(cc_if.cc_cmd), 32'd0);
        chk({name, "_cc_arg"}, cc_if.cc_arg, 32'd0);
        chk({name, "_cc_precnt"}, 32'(cc_if.cc_precnt), 32'd0);
        chk({name, "_cc_clkdiv"}, 32'(cc_if.cc_clkdiv), 32'd99);
        chk({name, "_card_ready"}, 32'(card_ready), 32'd0);
        chk({name, "_init_err"}, 32'(init_err), 32'd0);
        chk({name, "_card_type"}, 32'(card_type), 32'd0);
        chk({name, "_rca"}, 32'(rca), 32'd0);
        chk({name, "_rd_rdy"}, 32'(rd_rdy), 32'd0);
        chk({name, "_rd_done"}, 32'(rd_done), 32'd0);
        chk({name, "_rd_err"}, 32'(rd_err), 32'd0);
    endtask

    initial begin
        int n;
        rst = 1'b1; reinit = 1'b0; rd_req = 1'b0; rd_sector = 32'h0;
        cc_if.cc_busy = 1'b0; cc_if.cc_done = 1'b0; cc_if.cc_timeout = 1'b0;
        cc_if.cc_syntaxe = 1'b0; cc_if.cc_resparg = 32'h0;
        m_v2 = 1'b1; m_hc = 1'b1; m_always_busy = 1'b0; m_syn41 = 1'b1; m_rd_fail = 1'b0;
        m_busy_left = 3; m_cmd2_to = 0; m_rca = 16'h1234;
        pend = 1'b0; cnt = 0; infl_cmd = 6'd0; infl_arg = 32'h0;
        n_rd_done = 0; n_rd_err = 0; prev_clkdiv = 16'h0; prev_rst = 1'b1;
        clear_stats();
        repeat (3) tick();
        check_reset_values("reset");

        // v2 HC card, ACMD41 busy x3, syntaxe flagged on R3
        expect_init(1'b1, 1'b1, 3, 0, 16'h1234, 1'b0);
        rst = 1'b0;
        wait_settle("init_hc", 2000);
        chk("hc_card_type", 32'(card_type), 32'd3);
        chk("hc_rca", 32'(rca), 32'h1234);
        chk("hc_clkdiv", 32'(cc_if.cc_clkdiv), 32'd1);
        chk("hc_card_ready", 32'(card_ready), 32'd1);
        chk("hc_rd_rdy", 32'(rd_rdy), 32'd1);
        chk("hc_cmd7_arg", last_arg[7], 32'h1234_0000);
        chk("hc_cmd16_absent", 32'(n_start[16]), 32'd0);
        chk("hc_acmd41_count", 32'(n_start[41]), 32'd4);
        chk("hc_queue_empty", 32'(exp_q.size()), 32'd0);
        do_read("hc_read", 32'h0000_0003, 1'b1, 1'b0);
        chk("hc_cmd17_arg", last_arg[17], 32'h0000_0003);
        do_read("hc_read_fail", 32'h0000_0010, 1'b1, 1'b1);
        chk("hc_cmd17_attempts", 32'(n_start[17]), 32'd5);

        // simultaneous reinit + rd_req: reinit wins, v2 SC card follows
        m_hc = 1'b0; m_busy_left = 0; m_rca = 16'hBEEF; m_syn41 = 1'b0;
        clear_stats();
        expect_init(1'b1, 1'b0, 0, 0, 16'hBEEF, 1'b0);
        rd_sector = 32'h5;
        rd_req = 1'b1;
        pulse_reinit();
        rd_req = 1'b0;
        chk("reinit_card_ready", 32'(card_ready), 32'd0);
        chk("reinit_clkdiv", 32'(cc_if.cc_clkdiv), 32'd99);
        chk("reinit_card_type", 32'(card_type), 32'd0);
        wait_settle("init_sc", 2000);
        chk("sc_card_type", 32'(card_type), 32'd2);
        chk("sc_rca", 32'(rca), 32'hBEEF);
        chk("sc_cmd16_arg", last_arg[16], 32'd512);
        chk("sc_cmd17_absent", 32'(n_start[17]), 32'd0);
        chk("sc_queue_empty", 32'(exp_q.size()), 32'd0);
        do_read("sc_read", 32'h0000_0003, 1'b0, 1'b0);
        chk("sc_cmd17_arg", last_arg[17], 32'h0000_0600);
        do_read("sc_read_trunc", 32'hFFC0_0001, 1'b0, 1'b0);
        chk("sc_cmd17_trunc_arg", last_arg[17], 32'h8000_0200);

        // v1 card, with a reinit pulse mid-sequence that must be ignored
        m_v2 = 1'b0; m_busy_left = 1; m_rca = 16'h0042;
        clear_stats();
        expect_init(1'b0, 1'b0, 1, 0, 16'h0042, 1'b0);
        pulse_reinit();
        repeat (20) tick();
        pulse_reinit();
        wait_settle("init_v1", 2000);
        chk("v1_card_type", 32'(card_type), 32'd1);
        chk("v1_acmd41_arg", last_arg[41], 32'h0010_0000);
        chk("v1_cmd16_arg", last_arg[16], 32'd512);
        chk("v1_cmd0_count", 32'(n_start[0]), 32'd1);
        chk("v1_queue_empty", 32'(exp_q.size()), 32'd0);

        // CMD2 times out 3 times then answers
        m_v2 = 1'b1; m_hc = 1'b1; m_busy_left = 0; m_cmd2_to = 3; m_rca = 16'h0101;
        clear_stats();
        expect_init(1'b1, 1'b1, 0, 3, 16'h0101, 1'b0);
        pulse_reinit();
        wait_settle("init_cmd2_3to", 2000);
        chk("cmd2_3to_ready", 32'(card_ready), 32'd1);
        chk("cmd2_3to_count", 32'(n_start[2]), 32'd4);

        // CMD2 times out 4 times -> ERROR
        m_cmd2_to = 4;
        clear_stats();
        expect_init(1'b1, 1'b1, 0, 4, 16'h0101, 1'b0);
        pulse_reinit();
        wait_settle("init_cmd2_4to", 2000);
        repeat (20) tick();
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        repeat (5) tick();
        chk("cmd2_err_init_err", 32'(init_err), 32'd1);
        chk("cmd2_err_card_ready", 32'(card_ready), 32'd0);
        chk("cmd2_err_rd_rdy", 32'(rd_rdy), 32'd0);
        chk("cmd2_err_count", 32'(n_start[2]), 32'd4);
        chk("cmd2_err_queue_empty", 32'(exp_q.size()), 32'd0);

        // reinit from ERROR, ACMD41 never ready -> 2000 pairs then ERROR
        m_cmd2_to = 0; m_always_busy = 1'b1;
        clear_stats();
        expect_init(1'b1, 1'b1, 0, 0, 16'h0101, 1'b1);
        pulse_reinit();
        chk("err_reinit_init_err", 32'(init_err), 32'd0);
        chk("err_reinit_clkdiv", 32'(cc_if.cc_clkdiv), 32'd99);
        n = 0;
        while (n_start[0] == 0 && n < 20) begin
            tick();
            n++;
        end
        chk("err_reinit_cmd0_issued", 32'(n_start[0]), 32'd1);
        chk("err_reinit_cmd0_precnt", 32'(last_pre[0]), 32'd80);
        wait_settle("init_acmd41_busy", 40000);
        chk("busy_init_err", 32'(init_err), 32'd1);
        chk("busy_acmd41_count", 32'(n_start[41]), 32'd2000);
        chk("busy_cmd55_count", 32'(n_start[55]), 32'd2000);
        chk("busy_cmd2_absent", 32'(n_start[2]), 32'd0);
        chk("busy_queue_empty", 32'(exp_q.size()), 32'd0);

        // rst while CMD3 is in flight
        m_always_busy = 1'b0; m_busy_left = 0; m_rca = 16'h5678;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_q.delete();
        clear_stats();
        expect_init(1'b1, 1'b1, 0, 0, 16'h5678, 1'b0);
        n = 0;
        while (!(pend && infl_cmd == 6'd3) && n < 2000) begin
            tick();
            n++;
        end
        chk("rst_mid_reached_cmd3", 32'(infl_cmd), 32'd3);
        tick();
        rst = 1'b1;
        tick();
        check_reset_values("rst_mid");
        rst = 1'b0;
        exp_q.delete();
        clear_stats();
        expect_init(1'b1, 1'b1, 0, 0, 16'h5678, 1'b0);
        wait_settle("init_after_rst", 2000);
        chk("rst_restart_cmd0", 32'(n_start[0]), 32'd1);
        chk("rst_restart_precnt", 32'(last_pre[0]), 32'd80);
        chk("rst_restart_type", 32'(card_type), 32'd3);
        chk("rst_restart_rca", 32'(rca), 32'h5678);
        chk("rst_restart_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
